// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: joystick bit layout, rotation
// encoding, coin FSM states and PS/2 set-2 scan codes with key decode helpers.
package arcade_input_pkg;

  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_F1   = 4;
  localparam int JOY_F2   = 5;
  localparam int JOY_F3   = 6;
  localparam int JOY_COIN = 7;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_CW   = 2'd1,
    ROT_CCW  = 2'd2,
    ROT_180  = 2'd3
  } rot_e;

  typedef enum logic [1:0] {
    COIN_IDLE     = 2'd0,
    COIN_PULSE    = 2'd1,
    COIN_WAIT_REL = 2'd2
  } coin_state_e;

  localparam logic [7:0] SC_P0_UP    = 8'h75;
  localparam logic [7:0] SC_P0_DOWN  = 8'h72;
  localparam logic [7:0] SC_P0_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P0_RIGHT = 8'h74;
  localparam logic [7:0] SC_P0_F1    = 8'h29;
  localparam logic [7:0] SC_P0_F2    = 8'h11;
  localparam logic [7:0] SC_P0_F3    = 8'h14;
  localparam logic [7:0] SC_P1_UP    = 8'h2D;
  localparam logic [7:0] SC_P1_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P1_LEFT  = 8'h23;
  localparam logic [7:0] SC_P1_RIGHT = 8'h34;
  localparam logic [7:0] SC_P1_F1    = 8'h1C;
  localparam logic [7:0] SC_P1_F2    = 8'h1B;
  localparam logic [7:0] SC_P1_F3    = 8'h15;
  localparam logic [7:0] SC_START0   = 8'h05;
  localparam logic [7:0] SC_START1   = 8'h06;
  localparam logic [7:0] SC_START2   = 8'h04;
  localparam logic [7:0] SC_START3   = 8'h0C;
  localparam logic [7:0] SC_COIN     = 8'h76;

  // One-hot control bit hit by a scan code for player p; P0 arrows need E0.
  function automatic logic [6:0] ctrl_key_hit(input int p, input logic [7:0] code,
                                              input logic ext);
    logic [6:0] hit;
    hit = '0;
    if (p == 0) begin
      case (code)
        SC_P0_UP:    hit[JOY_U]  = ext;
        SC_P0_DOWN:  hit[JOY_D]  = ext;
        SC_P0_LEFT:  hit[JOY_L]  = ext;
        SC_P0_RIGHT: hit[JOY_R]  = ext;
        SC_P0_F1:    hit[JOY_F1] = 1'b1;
        SC_P0_F2:    hit[JOY_F2] = 1'b1;
        SC_P0_F3:    hit[JOY_F3] = 1'b1;
        default: ;
      endcase
    end else if (p == 1) begin
      case (code)
        SC_P1_UP:    hit[JOY_U]  = 1'b1;
        SC_P1_DOWN:  hit[JOY_D]  = 1'b1;
        SC_P1_LEFT:  hit[JOY_L]  = 1'b1;
        SC_P1_RIGHT: hit[JOY_R]  = 1'b1;
        SC_P1_F1:    hit[JOY_F1] = 1'b1;
        SC_P1_F2:    hit[JOY_F2] = 1'b1;
        SC_P1_F3:    hit[JOY_F3] = 1'b1;
        default: ;
      endcase
    end
    return hit;
  endfunction

  function automatic logic [3:0] start_key_hit(input logic [7:0] code);
    logic [3:0] hit;
    hit = '0;
    case (code)
      SC_START0: hit[0] = 1'b1;
      SC_START1: hit[1] = 1'b1;
      SC_START2: hit[2] = 1'b1;
      SC_START3: hit[3] = 1'b1;
      default: ;
    endcase
    return hit;
  endfunction

  // Directions in joystick bit order {U,D,L,R}.
  function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input rot_e rot);
    logic [3:0] r;
    r = d;
    case (rot)
      ROT_CW: begin
        r[JOY_U] = d[JOY_R]; r[JOY_R] = d[JOY_D];
        r[JOY_D] = d[JOY_L]; r[JOY_L] = d[JOY_U];
      end
      ROT_CCW: begin
        r[JOY_U] = d[JOY_L]; r[JOY_L] = d[JOY_D];
        r[JOY_D] = d[JOY_R]; r[JOY_R] = d[JOY_U];
      end
      ROT_180: begin
        r[JOY_U] = d[JOY_D]; r[JOY_D] = d[JOY_U];
        r[JOY_L] = d[JOY_R]; r[JOY_R] = d[JOY_L];
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/coin_pulser.sv
// Coin pulse generator: one fixed-width pulse per rising edge of the coin
// request, then waits for release before it can fire again.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE_CYCLES = 16'd65535
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic pulse
);

  coin_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_prev_q, req_prev_d;
  logic        pulse_q, pulse_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_prev_d = req;
    case (state_q)
      COIN_IDLE: begin
        if (req && !req_prev_q) begin
          state_d = COIN_PULSE;
          cnt_d   = '0;
        end
      end
      COIN_PULSE: begin
        if (cnt_q == COIN_PULSE_CYCLES - 16'd1) state_d = req ? COIN_WAIT_REL : COIN_IDLE;
        else                                     cnt_d   = cnt_q + 16'd1;
      end
      COIN_WAIT_REL: begin
        if (!req) state_d = COIN_IDLE;
      end
      default: state_d = COIN_IDLE;
    endcase
    pulse_d = (state_d == COIN_PULSE);
  end

  // Edge history resets high so a request held across reset never fires.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= COIN_IDLE;
      cnt_q      <= '0;
      req_prev_q <= 1'b1;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_prev_q <= req_prev_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and joysticks into per-player arcade controls with rotation,
// opposite-direction cancel and coin pulse. Define AUTOFIRE_EN for autofire on F1.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS       = 2,
  parameter logic [15:0] COIN_PULSE_CYCLES = 16'd65535,
  parameter logic [19:0] AUTOFIRE_DIV      = 20'd550000
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     key_strobe,
  input  logic                     key_pressed,
  input  logic                     key_extended,
  input  logic [7:0]               key_code,
  input  logic [8*NUM_PLAYERS-1:0] joy_in,
  input  logic [1:0]               rotate,
  output logic [7*NUM_PLAYERS-1:0] ctrl_out,
  output logic [NUM_PLAYERS-1:0]   start_out,
  output logic                     coin_out
`ifdef AUTOFIRE_EN
  ,
  input  logic [NUM_PLAYERS-1:0]   autofire
`endif
);

  logic [NUM_PLAYERS-1:0][6:0] key_lat_q, key_lat_d;
  logic [NUM_PLAYERS-1:0][6:0] ctrl_q, ctrl_d;
  logic [NUM_PLAYERS-1:0]      start_lat_q, start_lat_d;
  logic [NUM_PLAYERS-1:0]      start_q, start_d;
  logic                        coin_lat_q, coin_lat_d;
  logic                        coin_req;
  logic [6:0]                  hit;
  logic [3:0]                  start_hit;

  always_comb begin
    key_lat_d   = key_lat_q;
    start_lat_d = start_lat_q;
    coin_lat_d  = coin_lat_q;
    hit         = '0;
    start_hit   = start_key_hit(key_code);
    if (key_strobe) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        hit = ctrl_key_hit(p, key_code, key_extended);
        for (int b = 0; b < 7; b++)
          if (hit[b]) key_lat_d[p][b] = key_pressed;
        if (start_hit[p]) start_lat_d[p] = key_pressed;
      end
      if (key_code == SC_COIN) coin_lat_d = key_pressed;
    end
  end

  always_comb begin
    coin_req = coin_lat_q;
    for (int p = 0; p < NUM_PLAYERS; p++)
      coin_req = coin_req | joy_in[8*p + JOY_COIN];
  end

`ifdef AUTOFIRE_EN
  logic [19:0] af_cnt_q, af_cnt_d;
  logic        af_phase_q, af_phase_d;

  always_comb begin
    af_cnt_d   = af_cnt_q + 20'd1;
    af_phase_d = af_phase_q;
    if (af_cnt_q == AUTOFIRE_DIV - 20'd1) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [6:0] merged;
    logic [3:0] dirs;
    logic       f1;

    always_comb begin
      merged = key_lat_q[p] | joy_in[8*p +: 7];
      dirs   = rotate_dirs(merged[3:0], rot_e'(rotate));
      // Opposites cancel after rotation so the game never sees U+D or L+R.
      if (dirs[JOY_U] && dirs[JOY_D]) begin
        dirs[JOY_U] = 1'b0;
        dirs[JOY_D] = 1'b0;
      end
      if (dirs[JOY_L] && dirs[JOY_R]) begin
        dirs[JOY_L] = 1'b0;
        dirs[JOY_R] = 1'b0;
      end
      f1 = merged[JOY_F1];
`ifdef AUTOFIRE_EN
      if (autofire[p]) f1 = f1 & af_phase_q;
`endif
    end

    assign ctrl_d[p] = {merged[JOY_F3], merged[JOY_F2], f1, dirs};
  end

  assign start_d = start_lat_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_lat_q   <= '0;
      start_lat_q <= '0;
      coin_lat_q  <= 1'b0;
      ctrl_q      <= '0;
      start_q     <= '0;
    end else begin
      key_lat_q   <= key_lat_d;
      start_lat_q <= start_lat_d;
      coin_lat_q  <= coin_lat_d;
      ctrl_q      <= ctrl_d;
      start_q     <= start_d;
    end
  end

  coin_pulser #(
    .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset  (reset),
    .req    (coin_req),
    .pulse  (coin_out)
  );

  assign ctrl_out  = ctrl_q;
  assign start_out = start_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized + directed bench for arcade_input_mapper against a spec-level model;
// a 2-player and a 1-player instance share the PS/2 key stream.
module tb_arcade_input_mapper;

  localparam int N_COIN = 4;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        key_strobe, key_pressed, key_extended;
  logic [7:0]  key_code;
  logic [15:0] joy0;
  logic [7:0]  joy1;
  logic [1:0]  rotate;
  logic [13:0] ctrl0;
  logic [1:0]  start0;
  logic        coin0;
  logic [6:0]  ctrl1;
  logic [0:0]  start1;
  logic        coin1;
`ifdef AUTOFIRE_EN
  logic [1:0]  autofire;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .NUM_PLAYERS(2), .COIN_PULSE_CYCLES(16'd4), .AUTOFIRE_DIV(20'd3)
  ) u_dut (
    .clk_sys(clk_sys), .reset(rst), .key_strobe(key_strobe), .key_pressed(key_pressed),
    .key_extended(key_extended), .key_code(key_code), .joy_in(joy0), .rotate(rotate),
    .ctrl_out(ctrl0), .start_out(start0), .coin_out(coin0)
`ifdef AUTOFIRE_EN
    , .autofire(autofire)
`endif
  );

  arcade_input_mapper #(
    .NUM_PLAYERS(1), .COIN_PULSE_CYCLES(16'd4), .AUTOFIRE_DIV(20'd3)
  ) u_dut1 (
    .clk_sys(clk_sys), .reset(rst), .key_strobe(key_strobe), .key_pressed(key_pressed),
    .key_extended(key_extended), .key_code(key_code), .joy_in(joy1), .rotate(rotate),
    .ctrl_out(ctrl1), .start_out(start1), .coin_out(coin1)
`ifdef AUTOFIRE_EN
    , .autofire(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state, indexed [dut][player]
  logic [6:0] m_key   [2][2];
  logic       m_start [2][2];
  logic       m_coin  [2];
  logic [6:0] e_ctrl  [2][2];
  logic       e_start [2][2];
  logic       e_coin  [2];
  int         m_left  [2];
  logic       m_wait  [2];
  logic       m_prev  [2];

  // -1 none; 0..15 ctrl (player*8+bit); 16..19 start; 32 coin
  function automatic int key_target(input logic [7:0] c, input logic ext);
    case (c)
      8'h75: return ext ? 3 : -1;
      8'h72: return ext ? 2 : -1;
      8'h6B: return ext ? 1 : -1;
      8'h74: return ext ? 0 : -1;
      8'h29: return 4;
      8'h11: return 5;
      8'h14: return 6;
      8'h2D: return 8 + 3;
      8'h2B: return 8 + 2;
      8'h23: return 8 + 1;
      8'h34: return 8 + 0;
      8'h1C: return 8 + 4;
      8'h1B: return 8 + 5;
      8'h15: return 8 + 6;
      8'h05: return 16;
      8'h06: return 17;
      8'h04: return 18;
      8'h0C: return 19;
      8'h76: return 32;
      default: return -1;
    endcase
  endfunction

  function automatic logic [6:0] ref_ctrl(input logic [6:0] v, input int rot);
    logic u, d, l, r, nu, nd, nl, nr;
    {u, d, l, r} = v[3:0];
    case (rot)
      1:       begin nu = r; nr = d; nd = l; nl = u; end
      2:       begin nu = l; nl = d; nd = r; nr = u; end
      3:       begin nu = d; nd = u; nl = r; nr = l; end
      default: begin nu = u; nd = d; nl = l; nr = r; end
    endcase
    if (nu && nd) begin nu = 1'b0; nd = 1'b0; end
    if (nl && nr) begin nl = 1'b0; nr = 1'b0; end
    return {v[6:4], nu, nd, nl, nr};
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int np, t;
      logic [7:0] jb;
      logic req;
      np = (d == 0) ? 2 : 1;
      if (rst) begin
        for (int p = 0; p < 2; p++) begin
          m_key[d][p] = '0; m_start[d][p] = 1'b0;
          e_ctrl[d][p] = '0; e_start[d][p] = 1'b0;
        end
        m_coin[d] = 1'b0; m_left[d] = 0; m_wait[d] = 1'b0;
        m_prev[d] = 1'b1; e_coin[d] = 1'b0;
      end else begin
        req = m_coin[d];
        for (int p = 0; p < np; p++) begin
          jb = (d == 0) ? joy0[8*p +: 8] : joy1;
          e_ctrl[d][p]  = ref_ctrl(m_key[d][p] | jb[6:0], int'(rotate));
          e_start[d][p] = m_start[d][p];
          req = req | jb[7];
        end
        if (m_left[d] > 0) begin
          m_left[d]--;
          if (m_left[d] == 0 && req) m_wait[d] = 1'b1;
        end else if (m_wait[d]) begin
          if (!req) m_wait[d] = 1'b0;
        end else if (req && !m_prev[d]) begin
          m_left[d] = N_COIN;
        end
        e_coin[d] = (m_left[d] > 0);
        m_prev[d] = req;
        if (key_strobe) begin
          t = key_target(key_code, key_extended);
          if (t >= 0 && t < 16 && t / 8 < np) m_key[d][t/8][t%8] = key_pressed;
          else if (t >= 16 && t < 20 && t - 16 < np) m_start[d][t-16] = key_pressed;
          else if (t == 32) m_coin[d] = key_pressed;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    chk("ctrl", {18'd0, ctrl0}, {18'd0, e_ctrl[0][1], e_ctrl[0][0]});
    chk("start", {30'd0, start0}, {30'd0, e_start[0][1], e_start[0][0]});
    chk("coin", {31'd0, coin0}, {31'd0, e_coin[0]});
    chk("ctrl_np1", {25'd0, ctrl1}, {25'd0, e_ctrl[1][0]});
    chk("start_np1", {31'd0, start1}, {31'd0, e_start[1][0]});
    chk("coin_np1", {31'd0, coin1}, {31'd0, e_coin[1]});
    key_strobe = 1'b0;
  endtask

  task automatic press(input logic [7:0] code, input logic make, input logic ext);
    key_code = code; key_pressed = make; key_extended = ext; key_strobe = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_count(input int n, output int highs, output int rises);
    logic prev;
    highs = 0; rises = 0; prev = coin0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (coin0) highs++;
      if (coin0 && !prev) rises++;
      prev = coin0;
    end
  endtask

  logic [7:0] codes [19] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h11, 8'h14,
                             8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15,
                             8'h05, 8'h06, 8'h04, 8'h0C, 8'h76};

  initial begin
    int h, r, idx, last, ntr;
    logic s [20];
    rst = 1'b1; key_strobe = 1'b0; key_pressed = 1'b0; key_extended = 1'b0;
    key_code = '0; joy0 = '0; joy1 = '0; rotate = 2'd0;
`ifdef AUTOFIRE_EN
    autofire = 2'b00;
`endif
    cycle(); cycle();
    chk("rst_ctrl", {18'd0, ctrl0}, 32'd0);
    chk("rst_start", {30'd0, start0}, 32'd0);
    chk("rst_coin", {31'd0, coin0}, 32'd0);
    rst = 1'b0;

    // rotation of a held Up
    rotate = 2'd1; joy0 = 16'h0008;
    cycle();
    chk("rot_cw_u", {25'd0, ctrl0[6:0]}, 32'h02);
    rotate = 2'd3;
    cycle();
    chk("rot_180_u", {25'd0, ctrl0[6:0]}, 32'h04);

    // key L+R cancel, then release L
    rotate = 2'd0; joy0 = '0;
    do_reset();
    press(8'h6B, 1'b1, 1'b1); cycle();
    press(8'h74, 1'b1, 1'b1); cycle();
    cycle();
    chk("lr_cancel", {25'd0, ctrl0[6:0]}, 32'h00);
    press(8'h6B, 1'b0, 1'b1); cycle();
    cycle();
    chk("lr_release", {25'd0, ctrl0[6:0]}, 32'h01);
    press(8'h75, 1'b1, 1'b0); cycle();
    cycle();
    chk("p0_up_noext", {25'd0, ctrl0[6:0]}, 32'h01);

    // coin key held: single fixed-width pulse, re-press gives another
    do_reset();
    press(8'h76, 1'b1, 1'b0);
    run_count(20, h, r);
    chk("coin_width", h, N_COIN);
    chk("coin_pulses", r, 1);
    press(8'h76, 1'b0, 1'b0);
    run_count(4, h, r);
    press(8'h76, 1'b1, 1'b0);
    run_count(10, h, r);
    chk("coin_width2", h, N_COIN);
    chk("coin_pulses2", r, 1);

    // single-player instance ignores player 1 and start 1 keys
    press(8'h76, 1'b0, 1'b0); cycle();
    do_reset();
    press(8'h1C, 1'b1, 1'b0); cycle();
    press(8'h06, 1'b1, 1'b0); cycle();
    cycle(); cycle();
    chk("np1_ctrl", {25'd0, ctrl1}, 32'd0);
    chk("np1_start", {31'd0, start1}, 32'd0);
    chk("np2_start1", {30'd0, start0}, 32'h2);

    // reset during pulse cycle 2 with joystick coin held
    do_reset();
    cycle();
    joy0 = 16'h0080;
    cycle();
    chk("coin_begin", {31'd0, coin0}, 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    chk("coin_rst_drop", {31'd0, coin0}, 32'd0);
    rst = 1'b0;
    run_count(10, h, r);
    chk("coin_held_rst", h, 0);
    joy0 = '0; cycle();
    joy0 = 16'h0080;
    run_count(8, h, r);
    chk("coin_after_rel", h, N_COIN);
    joy0 = '0;

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) rotate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        joy0 = 16'($urandom);
        joy0[7]  = ($urandom_range(0, 9) == 0);
        joy0[15] = ($urandom_range(0, 9) == 0);
        joy1 = 8'($urandom);
        joy1[7] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 19);
        if (idx == 19) press(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        else if (idx < 4) press(codes[idx], 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        else if (idx < 7) press(codes[idx], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else press(codes[idx], 1'($urandom_range(0, 1)), 1'b0);
      end
      cycle();
    end

    // F1 held on player 0 with autofire
    rst = 1'b0; rotate = 2'd0; joy1 = '0;
    do_reset();
    joy0 = 16'h0010;
`ifdef AUTOFIRE_EN
    autofire = 2'b01;
`endif
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      s[i] = ctrl0[4];
    end
`ifdef AUTOFIRE_EN
    last = -1; ntr = 0;
    for (int i = 1; i < 20; i++) begin
      if (s[i] != s[i-1]) begin
        if (last >= 0) chk("af_gap", i - last, 3);
        last = i;
        ntr++;
      end
    end
    chk("af_toggles", {31'd0, ntr >= 5}, 32'd1);
`else
    last = 0; ntr = 0;
    for (int i = 2; i < 20; i += 3) chk("f1_hold", {31'd0, s[i]}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
